// File: rtl/audio_sample_scheduler_if.sv
// Sample ROM read bus between the scheduler (master) and the ROM (slave).
// Latency: mem_data is valid exactly one cycle after mem_rd.
// Backpressure: none; the ROM must answer every strobe on time.
interface audio_sample_scheduler_if #(
    parameter int ADDR_W = 17
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport master (output mem_rd, output mem_addr, input mem_data);
    modport slave  (input mem_rd, input mem_addr, output mem_data);
endinterface

// File: rtl/audio_sample_scheduler.sv
// Per-period fetch of BGM/don/ka samples from a shared ROM, saturating mix, held output.
// Latency: tick in cycle T -> sample_vld_o and new sample_out_o in cycle T+8.
// Backpressure: none; the consumer must take the sample_vld_o pulse.
module audio_sample_scheduler #(
    parameter logic [13:0] CYCLE    = 14'd12500,
    parameter int          ADDR_W   = 17,
    parameter int          BGM_BASE = 0,
    parameter int          BGM_LEN  = 65536,
    parameter int          DON_BASE = 65536,
    parameter int          DON_LEN  = 2048,
    parameter int          KA_BASE  = 67584,
    parameter int          KA_LEN   = 2048
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      bgm_en_i,
    input  logic                      don_trig_i,
    input  logic                      ka_trig_i,
    audio_sample_scheduler_if.master  mem,
    output logic [7:0]                sample_out_o,
    output logic                      sample_vld_o,
    output logic                      don_busy_o,
    output logic                      ka_busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_AC0, S_RD1, S_AC1, S_RD2, S_AC2, S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [13:0]         cnt_q;
    logic                tick;
    logic [2:0]          act_q;              // 0=BGM, 1=don, 2=ka
    logic [ADDR_W-1:0]   ptr_q [3];
    logic                don_pend_q, ka_pend_q;
    logic signed [9:0]   acc_q;
    logic [7:0]          sample_q;
    logic                vld_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                rd_en, ac_en, out_en;
    logic [1:0]          ch;
    logic signed [9:0]   delta;
    logic signed [9:0]   mix;
    logic [7:0]          mix_sat;

    function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] c);
        case (c)
            2'd0:    return ADDR_W'(BGM_BASE);
            2'd1:    return ADDR_W'(DON_BASE);
            default: return ADDR_W'(KA_BASE);
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] last_of(input logic [1:0] c);
        case (c)
            2'd0:    return ADDR_W'(BGM_LEN - 1);
            2'd1:    return ADDR_W'(DON_LEN - 1);
            default: return ADDR_W'(KA_LEN - 1);
        endcase
    endfunction

    assign tick = (cnt_q == CYCLE);

    // Frame sequencer next-state and per-state strobes; ch selects the channel being served.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        ac_en   = 1'b0;
        out_en  = 1'b0;
        ch      = 2'd0;
        case (state_q)
            S_IDLE: if (tick) state_d = S_RD0;
            S_RD0:  begin rd_en = 1'b1; ch = 2'd0; state_d = S_AC0; end
            S_AC0:  begin ac_en = 1'b1; ch = 2'd0; state_d = S_RD1; end
            S_RD1:  begin rd_en = 1'b1; ch = 2'd1; state_d = S_AC1; end
            S_AC1:  begin ac_en = 1'b1; ch = 2'd1; state_d = S_RD2; end
            S_RD2:  begin rd_en = 1'b1; ch = 2'd2; state_d = S_AC2; end
            S_AC2:  begin ac_en = 1'b1; ch = 2'd2; state_d = S_OUT; end
            S_OUT:  begin out_en = 1'b1; state_d = S_IDLE; end
            default: state_d = S_IDLE;
        endcase
    end

    // Address is only driven fresh while reading an active channel, otherwise it holds.
    assign mem.mem_rd   = rd_en & act_q[ch];
    assign mem.mem_addr = mem.mem_rd ? (base_of(ch) + ptr_q[ch]) : addr_q;

    // ROM bytes are offset-binary; re-centre to signed around 0x80.
    assign delta   = act_q[ch] ? ($signed({2'b00, mem.mem_data}) - 10'sd128) : 10'sd0;
    assign mix     = acc_q + 10'sd128;
    assign mix_sat = (mix < 10'sd0) ? 8'h00 : (mix > 10'sd255) ? 8'hFF : mix[7:0];

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Sample period counter; tick marks its last cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)    cnt_q <= '0;
        else if (tick) cnt_q <= '0;
        else           cnt_q <= cnt_q + 14'd1;
    end

    // Channel activation at tick, pending triggers, and pointer advance after each fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_q      <= '0;
            ptr_q[0]   <= '0;
            ptr_q[1]   <= '0;
            ptr_q[2]   <= '0;
            don_pend_q <= 1'b0;
            ka_pend_q  <= 1'b0;
        end else if (tick) begin
            act_q[0] <= bgm_en_i;
            if (!bgm_en_i) ptr_q[0] <= '0;
            if (don_pend_q || don_trig_i) begin
                act_q[1] <= 1'b1;
                ptr_q[1] <= '0;
            end
            if (ka_pend_q || ka_trig_i) begin
                act_q[2] <= 1'b1;
                ptr_q[2] <= '0;
            end
            don_pend_q <= 1'b0;
            ka_pend_q  <= 1'b0;
        end else begin
            don_pend_q <= don_pend_q | don_trig_i;
            ka_pend_q  <= ka_pend_q | ka_trig_i;
            if (ac_en && act_q[ch]) begin
                if (ptr_q[ch] == last_of(ch)) begin
                    ptr_q[ch] <= '0;
                    // BGM loops; one-shots retire at their last sample.
                    if (ch != 2'd0) act_q[ch] <= 1'b0;
                end else begin
                    ptr_q[ch] <= ptr_q[ch] + 1'b1;
                end
            end
        end
    end

    // Mix accumulator, held output sample, valid pulse and held ROM address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            sample_q <= 8'h80;
            vld_q    <= 1'b0;
            addr_q   <= '0;
        end else begin
            addr_q <= mem.mem_addr;
            vld_q  <= out_en;
            if (ac_en) acc_q <= acc_q + delta;
            if (out_en) begin
                sample_q <= mix_sat;
                acc_q    <= '0;
            end
        end
    end

    assign sample_out_o = sample_q;
    assign sample_vld_o = vld_q;
    assign don_busy_o   = act_q[1];
    assign ka_busy_o    = act_q[2];

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Bench for audio_sample_scheduler: directed scenarios plus random triggers vs a frame-level model.
// Latency: model predicts each frame's output 8 cycles after its tick.
// Backpressure: none on the DUT; the bench ROM answers every read one cycle later.
module tb_audio_sample_scheduler;

    localparam int BGM_LEN  = 4;
    localparam int DON_LEN  = 3;
    localparam int KA_LEN   = 3;
    localparam int BGM_BASE = 0;
    localparam int DON_BASE = 4;
    localparam int KA_BASE  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bgm_en = 1'b0;
    logic       don_trig = 1'b0;
    logic       ka_trig = 1'b0;
    logic [7:0] sample_out;
    logic       sample_vld;
    logic       don_busy;
    logic       ka_busy;
    logic [7:0] rom [16];

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level reference model state.
    int   m_cnt = 0, m_due = 0, m_bptr = 0, m_dptr = 0, m_kptr = 0;
    bit   m_bon = 0, m_don = 0, m_kon = 0, m_dpend = 0, m_kpend = 0;
    bit   m_dvis = 0, m_kvis = 0, m_dend = 0, m_kend = 0;
    bit   m_fa [3] = '{0, 0, 0};
    int   m_faddr [3] = '{0, 0, 0};
    logic [7:0] m_out = 8'h80, m_next = 8'h80;

    audio_sample_scheduler_if #(.ADDR_W(17)) mif ();

    audio_sample_scheduler #(
        .CYCLE(14'd15), .ADDR_W(17),
        .BGM_BASE(BGM_BASE), .BGM_LEN(BGM_LEN),
        .DON_BASE(DON_BASE), .DON_LEN(DON_LEN),
        .KA_BASE(KA_BASE),   .KA_LEN(KA_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bgm_en_i(bgm_en), .don_trig_i(don_trig), .ka_trig_i(ka_trig),
        .mem(mif), .sample_out_o(sample_out), .sample_vld_o(sample_vld),
        .don_busy_o(don_busy), .ka_busy_o(ka_busy)
    );

    always #5 clk = ~clk;

    // One-cycle-latency ROM.
    always @(posedge clk) begin
        if (mif.mem_rd) mif.mem_data <= rom[mif.mem_addr[3:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] clamp(input int v);
        if (v < 0)   return 8'h00;
        if (v > 255) return 8'hFF;
        return 8'(v);
    endfunction

    // Advance the model by one clock edge using the inputs applied this cycle.
    task automatic model_update();
        int sum;
        if (!rst_n) begin
            m_cnt = 0; m_due = 0; m_out = 8'h80; m_bon = 0; m_bptr = 0;
            m_don = 0; m_dptr = 0; m_kon = 0; m_kptr = 0; m_dpend = 0; m_kpend = 0;
            m_dvis = 0; m_kvis = 0; m_dend = 0; m_kend = 0; m_fa = '{0, 0, 0};
            return;
        end
        if (m_due > 0) begin
            m_due--;
            if (m_due == 4 && m_dend) m_dvis = 0;
            if (m_due == 2 && m_kend) m_kvis = 0;
            if (m_due == 1) m_out = m_next;
        end
        if (m_cnt == 15) begin
            m_cnt = 0;
            m_bon = bgm_en;
            if (!bgm_en) m_bptr = 0;
            if (m_dpend || don_trig) begin m_don = 1; m_dptr = 0; end
            if (m_kpend || ka_trig)  begin m_kon = 1; m_kptr = 0; end
            m_dpend = 0; m_kpend = 0;
            sum = 128; m_fa = '{0, 0, 0}; m_dend = 0; m_kend = 0;
            if (m_bon) begin
                m_fa[0] = 1; m_faddr[0] = BGM_BASE + m_bptr;
                sum += int'(rom[m_faddr[0]]) - 128;
                m_bptr = (m_bptr + 1) % BGM_LEN;
            end
            if (m_don) begin
                m_fa[1] = 1; m_faddr[1] = DON_BASE + m_dptr;
                sum += int'(rom[m_faddr[1]]) - 128;
                m_dptr++;
                if (m_dptr == DON_LEN) begin m_don = 0; m_dptr = 0; m_dend = 1; end
            end
            if (m_kon) begin
                m_fa[2] = 1; m_faddr[2] = KA_BASE + m_kptr;
                sum += int'(rom[m_faddr[2]]) - 128;
                m_kptr++;
                if (m_kptr == KA_LEN) begin m_kon = 0; m_kptr = 0; m_kend = 1; end
            end
            m_dvis = m_fa[1];
            m_kvis = m_fa[2];
            m_next = clamp(sum);
            m_due  = 8;
        end else begin
            m_cnt++;
            m_dpend |= don_trig;
            m_kpend |= ka_trig;
        end
    endtask

    // Compare all outputs for the current cycle, then clock once.
    task automatic step();
        logic        exp_rd;
        logic [31:0] exp_addr;
        @(negedge clk);
        exp_rd = 1'b0; exp_addr = '0;
        if (m_due == 8 && m_fa[0]) begin exp_rd = 1'b1; exp_addr = m_faddr[0]; end
        if (m_due == 6 && m_fa[1]) begin exp_rd = 1'b1; exp_addr = m_faddr[1]; end
        if (m_due == 4 && m_fa[2]) begin exp_rd = 1'b1; exp_addr = m_faddr[2]; end
        check("sample_vld", sample_vld, (m_due == 1));
        check("sample_out", sample_out, m_out);
        check("mem_rd", mif.mem_rd, exp_rd);
        if (exp_rd) check("mem_addr", mif.mem_addr, exp_addr);
        check("don_busy", don_busy, m_dvis);
        check("ka_busy", ka_busy, m_kvis);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_cnt(input int c);
        int n = 0;
        while (m_cnt != c && n < 100) begin step(); n++; end
        if (n >= 100) check("wait_cnt_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_due(input int d);
        int n = 0;
        while (m_due != d && n < 100) begin step(); n++; end
        if (n >= 100) check("wait_due_timeout", 32'd1, 32'd0);
    endtask

    task automatic pulse_don();
        don_trig = 1'b1; step(); don_trig = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
        mif.mem_data = 8'h00;

        // Reset, then three silent periods.
        run(3);
        rst_n = 1'b1;
        run(50);

        // BGM loop with wrap.
        wait_due(0);
        rom[0] = 8'h90; rom[1] = 8'h70; rom[2] = 8'hFF; rom[3] = 8'h00;
        bgm_en = 1'b1;
        run(16 * 6);
        bgm_en = 1'b0;
        wait_due(0);

        // Don one-shot alone.
        rom[4] = 8'hA0; rom[5] = 8'hB0; rom[6] = 8'hC0;
        pulse_don();
        run(16 * 5);

        // Clamp high, then clamp low.
        wait_due(0);
        for (int i = 0; i < 16; i++) rom[i] = 8'hFF;
        bgm_en = 1'b1; don_trig = 1'b1; ka_trig = 1'b1; step();
        don_trig = 1'b0; ka_trig = 1'b0;
        run(40);
        wait_due(0);
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        don_trig = 1'b1; ka_trig = 1'b1; step();
        don_trig = 1'b0; ka_trig = 1'b0;
        run(40);
        bgm_en = 1'b0;

        // Trigger on the tick cycle, then again mid-playback.
        wait_due(0);
        rom[4] = 8'h11; rom[5] = 8'h22; rom[6] = 8'h33;
        wait_cnt(15);
        pulse_don();
        wait_cnt(7);
        pulse_don();
        run(16 * 4);

        // Reset during AC1 with BGM and don active.
        rom[0] = 8'h90; rom[1] = 8'h70; rom[2] = 8'hFF; rom[3] = 8'h00;
        bgm_en = 1'b1;
        pulse_don();
        wait_cnt(0);
        wait_due(5);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        run(16 * 3);

        // Randomized inputs, ROM contents and occasional resets.
        wait_due(0);
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 39) == 0) bgm_en = ~bgm_en;
            don_trig = ($urandom_range(0, 11) == 0);
            ka_trig  = ($urandom_range(0, 11) == 0);
            rst_n    = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1'b1; don_trig = 1'b0; ka_trig = 1'b0;
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
